// File: rtl/rcpu_mem_pkg.sv
// Shared widths, FSM state type and default doorbell constants for the
// RCPU memory responder.
package rcpu_mem_pkg;

    // Data word width and CPU address width
    localparam int M = 16;
    localparam int N = 32;

    // Default doorbell location and interrupt vector
    localparam logic [N-1:0] DEFAULT_DOORBELL_ADDR = 32'hFFFF_FFF0;
    localparam logic [N-1:0] DEFAULT_INT_VECTOR    = 32'h0000_0100;

    // Read handshake states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } mem_state_e;

endpackage

// File: rtl/rcpu_mem_array.sv
// 2^AW x 16 word RAM: synchronous write, combinational read, no reset.
module rcpu_mem_array
    import rcpu_mem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [M-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [M-1:0]  rdata
);

    logic [M-1:0] ram [2**AW];

    // Store write data on the rising edge; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    assign rdata = ram[raddr];

endmodule

// File: rtl/rcpu_mem_responder.sv
// Memory responder for the RCPU: wait-stated read handshake, unstalled
// writes, out-of-range decode and an optional doorbell interrupt.
// Optional feature: define RCPU_MEM_DOORBELL_EN to enable the doorbell.
module rcpu_mem_responder
    import rcpu_mem_pkg::*;
#(
    parameter int           AW            = 12,
    parameter int           WAIT_STATES   = 2,
    parameter logic [N-1:0] DOORBELL_ADDR = DEFAULT_DOORBELL_ADDR,
    parameter logic [N-1:0] INT_VECTOR    = DEFAULT_INT_VECTOR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] memAddr,
    input  logic [M-1:0] memWrite,
    input  logic         memRE,
    input  logic         memWE,
    output logic [M-1:0] memRead,
    output logic         memReady,
    output logic         irq,
    input  logic         turnOffIRQ,
    output logic [N-1:0] intAddr,
    output logic [M-1:0] intData
);

    // Counter value on the final wait cycle
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    mem_state_e   state_q, state_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic [N-1:0] addr_q, addr_d;
    logic [M-1:0] mem_read_q, mem_read_d;
    logic         mem_ready_q, mem_ready_d;

    logic [N-1:0] rd_addr;
    logic         wr_in_range;
    logic         rd_in_range;
    logic         db_wr;
    logic         db_rd;
    logic         ram_we;
    logic         wr_bypass;
    logic [M-1:0] ram_rdata;
    logic [M-1:0] rd_data;
    logic [M-1:0] db_data;

    // In IDLE the live address is the one being accepted; afterwards the
    // latched address is used so later bus activity cannot redirect the read
    assign rd_addr     = (state_q == IDLE) ? memAddr : addr_q;
    assign wr_in_range = (memAddr >> AW) == '0;
    assign rd_in_range = (rd_addr >> AW) == '0;

`ifdef RCPU_MEM_DOORBELL_EN
    logic         irq_q, irq_d;
    logic [M-1:0] int_data_q, int_data_d;
    logic [N-1:0] int_addr_q, int_addr_d;

    assign db_wr = memWE && (memAddr == DOORBELL_ADDR);
    assign db_rd = (rd_addr == DOORBELL_ADDR);

    // Doorbell write raises irq and wins over a same-edge acknowledge
    always_comb begin
        irq_d      = irq_q;
        int_data_d = int_data_q;
        int_addr_d = int_addr_q;
        if (turnOffIRQ) begin
            irq_d = 1'b0;
        end
        if (db_wr) begin
            irq_d      = 1'b1;
            int_data_d = memWrite;
            int_addr_d = INT_VECTOR;
        end
    end

    // Doorbell registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q      <= 1'b0;
            int_data_q <= '0;
            int_addr_q <= '0;
        end else begin
            irq_q      <= irq_d;
            int_data_q <= int_data_d;
            int_addr_q <= int_addr_d;
        end
    end

    // A doorbell read sees a payload written on the same edge
    assign db_data = int_data_d;
    assign irq     = irq_q;
    assign intData = int_data_q;
    assign intAddr = int_addr_q;
`else
    logic unused_doorbell;

    assign db_wr   = 1'b0;
    assign db_rd   = 1'b0;
    assign db_data = '0;
    assign irq     = 1'b0;
    assign intData = '0;
    assign intAddr = '0;
    assign unused_doorbell = ^{turnOffIRQ, DOORBELL_ADDR, INT_VECTOR};
`endif

    // Doorbell writes never land in the RAM; out-of-range writes are dropped
    assign ram_we    = memWE && wr_in_range && !db_wr;
    assign wr_bypass = ram_we && (memAddr == rd_addr);

    rcpu_mem_array #(
        .AW(AW)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .waddr(memAddr[AW-1:0]),
        .wdata(memWrite),
        .raddr(rd_addr[AW-1:0]),
        .rdata(ram_rdata)
    );

    // Read data source; a write to the read address on the capture edge wins
    always_comb begin
        if (db_rd) begin
            rd_data = db_data;
        end else if (!rd_in_range) begin
            rd_data = '0;
        end else if (wr_bypass) begin
            rd_data = memWrite;
        end else begin
            rd_data = ram_rdata;
        end
    end

    // Next-state logic for the read handshake; data is captured on entry to READY
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        mem_read_d  = mem_read_q;
        mem_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (memRE) begin
                    addr_d     = memAddr;
                    wait_cnt_d = '0;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d     = READY;
                        mem_ready_d = 1'b1;
                        mem_read_d  = rd_data;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = READY;
                    wait_cnt_d  = '0;
                    mem_ready_d = 1'b1;
                    mem_read_d  = rd_data;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            READY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake registers; reset drops any pending read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            mem_read_q  <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            mem_read_q  <= mem_read_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign memRead  = mem_read_q;
    assign memReady = mem_ready_q;

endmodule

// File: doc/rcpu_mem_responder.md
RCPU_MEM_RESPONDER -- requirements
Module: rcpu_mem_responder

Interface
REQ-001 SHALL have parameter AW, default 12, meaning word-address width of the internal RAM (2^AW 16-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning extra read wait cycles (legal range 0..15).
REQ-003 SHALL have parameter DOORBELL_ADDR, default 32'hFFFF_FFF0, meaning the doorbell word address.
REQ-004 SHALL have parameter INT_VECTOR, default 32'h0000_0100, meaning the value driven on intAddr when the doorbell fires.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 memAddr  input  32  word address from the CPU.
REQ-008 memWrite  input  16  write data from the CPU.
REQ-009 memRE  input  1  read request; held high by the CPU until memReady.
REQ-010 memWE  input  1  write strobe; single-cycle, never stalled.
REQ-011 memRead  output  16  read data; valid only while memReady=1.
REQ-012 memReady  output  1  read completion; CPU captures memRead on the same edge.
REQ-013 irq  output  1  doorbell interrupt request.
REQ-014 turnOffIRQ  input  1  interrupt acknowledge from the CPU.
REQ-015 intAddr  output  32  interrupt vector.
REQ-016 intData  output  16  doorbell payload.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and READY, all registered.
- IDLE: memRE=1 latches memAddr; go to WAIT if WAIT_STATES>0, else to READY.
- WAIT: count WAIT_STATES cycles, then go to READY.
- READY: memReady=1 for exactly one cycle, then go to IDLE.
REQ-018 Read first sampled in cycle N SHALL assert memReady in cycle N+1+WAIT_STATES; memReady SHALL be 0 in all other states.
REQ-019 Read data SHALL come from the latched address; memAddr changes after acceptance SHALL be ignored.
REQ-020 memRE still high in the cycle after READY SHALL be treated as a new request (back-to-back reads: one idle cycle between readies).
REQ-021 Writes: memWE=1 SHALL write memWrite to the array on that edge in any FSM state, with no handshake.
REQ-022 A write to the pending read address before READY SHALL be visible in the returned data (write-first).
REQ-023 memRE and memWE both high in IDLE SHALL perform the write and accept the read, which returns the new data.
REQ-024 Out-of-range address (any bit [31:AW] set) SHALL handle reads and writes as follows:
- reads complete with normal latency and return 16'h0000;
- writes are discarded.
REQ-025 memRead SHALL hold its last value outside READY.

Reset
REQ-026 rst=0 SHALL force the following, asynchronously:
- FSM to IDLE and wait counter to 0;
- memReady=0, memRead=16'h0000;
- irq=0, intData=16'h0000, intAddr=32'h0.
REQ-027 Reset during WAIT or READY SHALL drop the pending read with no memReady pulse.
REQ-028 RAM contents SHALL NOT be reset.

Configuration
REQ-029 With RCPU_MEM_DOORBELL_EN defined, the doorbell SHALL behave as follows:
- a write to DOORBELL_ADDR sets irq=1, intData=memWrite and intAddr=INT_VECTOR on the next edge;
- turnOffIRQ=1 clears irq;
- a doorbell write and turnOffIRQ on the same edge leave irq=1 with the new data;
- a read of DOORBELL_ADDR returns the current intData.
REQ-030 Without RCPU_MEM_DOORBELL_EN:
- irq, intAddr and intData SHALL be tied to 0;
- turnOffIRQ SHALL be ignored;
- DOORBELL_ADDR SHALL behave as an ordinary address.

Structure
REQ-031 Package rcpu_mem_pkg SHALL hold:
- M=16 and N=32 width constants;
- the FSM state typedef (IDLE/WAIT/READY);
- the default DOORBELL_ADDR and INT_VECTOR constants.
REQ-032 RAM SHALL be sub-module rcpu_mem_array (2^AW x 16, synchronous write, combinational read); FSM, decode and doorbell logic stay in the top.

Verification
REQ-033 WAIT_STATES=2: write 16'hBEEF to 32'h10, then hold memRE at 32'h10 from cycle 5 -> memReady=1 only in cycle 8 with memRead=16'hBEEF.
REQ-034 WAIT_STATES=0: memRE held for 3 consecutive reads of 32'h0..32'h2 -> memReady pulses in cycles N+1, N+3, N+5 with correct data.
REQ-035 Read of 32'h20 pending; write 16'h1234 to 32'h20 during WAIT -> returned data is 16'h1234.
REQ-036 Read of 32'h0001_0000 with AW=12 -> memRead=16'h0000 with normal latency; a write to that address leaves word 0 unchanged.
REQ-037 rst=0 asserted in WAIT -> memReady never pulses; FSM is IDLE after release; a new read completes normally.
REQ-038 With RCPU_MEM_DOORBELL_EN, write 16'h00A5 to DOORBELL_ADDR -> irq=1, intData=16'h00A5, intAddr=INT_VECTOR; turnOffIRQ then clears irq; a doorbell write on the same edge as turnOffIRQ keeps irq=1.
